// File: rtl/router_olck_pkg.sv
// Shared types and width helpers for the router output-port lock/credit controller.
package router_olck_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } olck_state_e;

    function automatic int owner_width(input int num_in);
        return (num_in < 2) ? 1 : $clog2(num_in);
    endfunction

    function automatic int credit_width(input int credits);
        return $clog2(credits + 1);
    endfunction

    localparam int DEF_NUM_IN  = 4;
    localparam int DEF_CREDITS = 4;
    localparam int OWNER_W     = owner_width(DEF_NUM_IN);
    localparam int CREDIT_W    = credit_width(DEF_CREDITS);

endpackage

// File: rtl/router_rr_arbiter.sv
// Combinational round-robin select: first requester at or after i_ptr wins.
module router_rr_arbiter
    import router_olck_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int OWNER_W = owner_width(NUM_IN)
) (
    input  logic [NUM_IN-1:0]  i_req,
    input  logic [OWNER_W-1:0] i_ptr,
    output logic [NUM_IN-1:0]  o_gnt,
    output logic [OWNER_W-1:0] o_idx,
    output logic               o_any
);

    logic [OWNER_W-1:0] w_idx;
    int                 w_sum;

    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_idx = '0;
        w_sum = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            // Walk the ring starting at the pointer, wrapping past the last input.
            w_sum = int'(i_ptr) + k;
            if (w_sum >= NUM_IN) begin
                w_sum = w_sum - NUM_IN;
            end
            w_idx = OWNER_W'(w_sum);
            if (!o_any && i_req[w_idx]) begin
                o_any        = 1'b1;
                o_gnt[w_idx] = 1'b1;
                o_idx        = w_idx;
            end
        end
    end

endmodule

// File: rtl/router_olck_ctrl.sv
// Output-port lock and credit controller: arbitrates heads, holds the port until
// the tail transfers, and meters flits against downstream buffer credits.
module router_olck_ctrl
    import router_olck_pkg::*;
#(
    parameter int NUM_IN  = DEF_NUM_IN,
    parameter int FLIT_W  = 32,
    parameter int CREDITS = DEF_CREDITS
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_IN-1:0]                in_valid,
    input  logic [NUM_IN-1:0]                in_head,
    input  logic [NUM_IN-1:0]                in_tail,
    input  logic [NUM_IN*FLIT_W-1:0]         in_flit,
    output logic [NUM_IN-1:0]                in_ready,
    output logic                             out_valid,
    output logic [FLIT_W-1:0]                out_flit,
    output logic                             out_lock,
    output logic [owner_width(NUM_IN)-1:0]   out_owner,
    input  logic                             credit_ret,
    output logic [credit_width(CREDITS)-1:0] credit_cnt,
    output logic                             credit_err
);

    localparam int OWN_W = owner_width(NUM_IN);
    localparam int CRD_W = credit_width(CREDITS);
    localparam logic [OWN_W-1:0] LAST_IN  = OWN_W'(NUM_IN - 1);
    localparam logic [CRD_W-1:0] FULL_CRD = CRD_W'(CREDITS);

    olck_state_e        r_state;
    olck_state_e        w_state_nxt;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   r_rr_ptr;
    logic               r_out_valid;
    logic [FLIT_W-1:0]  r_out_flit;
    logic [CRD_W-1:0]   r_credit;
    logic               r_err;

    logic [NUM_IN-1:0]  w_cand;
    logic [NUM_IN-1:0]  w_gnt;
    logic [OWN_W-1:0]   w_gnt_idx;
    logic               w_gnt_any;
    logic               w_has_credit;
    logic               w_xfer;
    logic               w_tail_xfer;
    logic [OWN_W-1:0]   w_rr_next;
    logic [NUM_IN-1:0]  w_ready;
    logic [FLIT_W-1:0]  w_owner_flit;

    assign w_cand = in_valid & in_head;

    router_rr_arbiter #(
        .NUM_IN  (NUM_IN),
        .OWNER_W (OWN_W)
    ) u_arb (
        .i_req (w_cand),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_gnt_idx),
        .o_any (w_gnt_any)
    );

    assign w_has_credit = (r_credit != '0);
    assign w_xfer       = (r_state == LOCKED) && in_valid[r_owner] && w_has_credit;
    assign w_tail_xfer  = w_xfer && in_tail[r_owner];
    assign w_rr_next    = (r_owner == LAST_IN) ? '0 : r_owner + 1'b1;
    assign w_owner_flit = in_flit[int'(r_owner)*FLIT_W +: FLIT_W];

    always_comb begin
        w_ready = '0;
        if (r_state == LOCKED) begin
            w_ready[r_owner] = w_has_credit;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_gnt_any)   w_state_nxt = LOCKED;
            LOCKED:  if (w_tail_xfer) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_owner  <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_gnt_any) begin
                r_owner <= w_gnt_idx;
            end
            if (w_tail_xfer) begin
                r_rr_ptr <= w_rr_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_valid <= 1'b0;
            r_out_flit  <= '0;
        end else begin
            r_out_valid <= w_xfer;
            if (w_xfer) begin
                r_out_flit <= w_owner_flit;
            end
        end
    end

    // A return that would exceed the buffer depth is dropped and flagged until reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_credit <= FULL_CRD;
            r_err    <= 1'b0;
        end else begin
            case ({w_xfer, credit_ret})
                2'b10: r_credit <= r_credit - 1'b1;
                2'b01: begin
                    if (r_credit == FULL_CRD) begin
                        r_err <= 1'b1;
                    end else begin
                        r_credit <= r_credit + 1'b1;
                    end
                end
                default: r_credit <= r_credit;
            endcase
        end
    end

    assign in_ready   = w_ready;
    assign out_valid  = r_out_valid;
    assign out_flit   = r_out_flit;
    assign out_lock   = (r_state == LOCKED);
    assign out_owner  = r_owner;
    assign credit_cnt = r_credit;
    assign credit_err = r_err;

    logic w_unused;
    assign w_unused = ^w_gnt;

endmodule

// File: tb/tb_router_olck_ctrl.sv
// Directed bench for router_olck_ctrl: vector table plus hand-written credit/reset sequences.
module tb_router_olck_ctrl;

    logic         clk;
    logic         reset;
    logic [3:0]   in_valid, in_head, in_tail;
    logic [127:0] in_flit;
    logic [3:0]   in_ready;
    logic         out_valid;
    logic [31:0]  out_flit;
    logic         out_lock;
    logic [1:0]   out_owner;
    logic         credit_ret;
    logic [2:0]   credit_cnt;
    logic         credit_err;

    int n_vec;
    int n_miss;

    router_olck_ctrl #(.NUM_IN(4), .FLIT_W(32), .CREDITS(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_head    (in_head),
        .in_tail    (in_tail),
        .in_flit    (in_flit),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_flit   (out_flit),
        .out_lock   (out_lock),
        .out_owner  (out_owner),
        .credit_ret (credit_ret),
        .credit_cnt (credit_cnt),
        .credit_err (credit_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  v, h, t;
        logic [31:0] base;
        logic        cr;
        logic [3:0]  rdy;
        logic        ov;
        logic [31:0] of;
        logic        lock;
        logic [1:0]  own;
        logic [2:0]  cnt;
        logic        err;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic rst, input logic [3:0] v, h, t,
                                input logic [31:0] base, input logic cr,
                                input logic [3:0] rdy, input logic ov, input logic [31:0] of,
                                input logic lock, input logic [1:0] own,
                                input logic [2:0] cnt, input logic err);
        vec_t e;
        e = '{rst, v, h, t, base, cr, rdy, ov, of, lock, own, cnt, err};
        tbl.push_back(e);
    endfunction

    // Lane i carries base+i so a wrong lane select shows up in out_flit.
    task automatic drive(input logic rst, input logic [3:0] v, h, t,
                         input logic [31:0] base, input logic cr);
        reset      = rst;
        in_valid   = v;
        in_head    = h;
        in_tail    = t;
        credit_ret = cr;
        for (int i = 0; i < 4; i++) in_flit[i*32 +: 32] = base + 32'(i);
    endtask

    task automatic ck(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic obs(input string tag, input logic [3:0] rdy, input logic ov,
                       input logic [31:0] of, input logic lock, input logic [1:0] own,
                       input logic [2:0] cnt, input logic err);
        @(negedge clk);
        ck({tag, ".in_ready"},   32'(in_ready),   32'(rdy));
        ck({tag, ".out_valid"},  32'(out_valid),  32'(ov));
        ck({tag, ".out_flit"},   out_flit,        of);
        ck({tag, ".out_lock"},   32'(out_lock),   32'(lock));
        ck({tag, ".out_owner"},  32'(out_owner),  32'(own));
        ck({tag, ".credit_cnt"}, 32'(credit_cnt), 32'(cnt));
        ck({tag, ".credit_err"}, 32'(credit_err), 32'(err));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected finish earlier");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec  = 0;
        n_miss = 0;

        // rst   v       h       t       base          cr | rdy    ov  out_flit     lk own cnt err
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 32'h0,        0, 0, 4, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 32'hA1000000, 0, 4'b0000, 0, 32'h0,        0, 0, 4, 0);
        add(0, 4'b0100, 4'b0100, 4'b0000, 32'hA1000000, 0, 4'b0100, 0, 32'h0,        1, 2, 4, 0);
        add(0, 4'b0100, 4'b0000, 4'b0000, 32'hA2000000, 0, 4'b0100, 1, 32'hA1000002, 1, 2, 3, 0);
        add(0, 4'b0100, 4'b0000, 4'b0100, 32'hA3000000, 0, 4'b0100, 1, 32'hA2000002, 1, 2, 2, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 1, 32'hA3000002, 0, 2, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 32'hA3000002, 0, 2, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 32'hA3000002, 0, 2, 2, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 32'hA3000002, 0, 2, 3, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 32'hA3000002, 0, 2, 4, 0);
        add(1, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 32'hA3000002, 0, 2, 4, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 32'h0,        0, 0, 4, 0);
        add(0, 4'b0011, 4'b0011, 4'b0011, 32'hB0000000, 0, 4'b0000, 0, 32'h0,        0, 0, 4, 0);
        add(0, 4'b0011, 4'b0011, 4'b0011, 32'hB0000000, 0, 4'b0001, 0, 32'h0,        1, 0, 4, 0);
        add(0, 4'b0010, 4'b0010, 4'b0010, 32'hB0000000, 0, 4'b0000, 1, 32'hB0000000, 0, 0, 3, 0);
        add(0, 4'b0010, 4'b0010, 4'b0010, 32'hB0000000, 0, 4'b0010, 0, 32'hB0000000, 1, 1, 3, 0);
        add(0, 4'b1111, 4'b1111, 4'b1111, 32'hC0000000, 0, 4'b0000, 1, 32'hB0000001, 0, 1, 2, 0);
        add(0, 4'b1111, 4'b1111, 4'b1111, 32'hC0000000, 0, 4'b0100, 0, 32'hB0000001, 1, 2, 2, 0);
        add(0, 4'b1011, 4'b1011, 4'b1011, 32'hC0000000, 0, 4'b0000, 1, 32'hC0000002, 0, 2, 1, 0);
        add(0, 4'b1011, 4'b1011, 4'b1011, 32'hC0000000, 0, 4'b1000, 0, 32'hC0000002, 1, 3, 1, 0);
        add(0, 4'b0011, 4'b0011, 4'b0011, 32'hC0000000, 0, 4'b0000, 1, 32'hC0000003, 0, 3, 0, 0);
        add(0, 4'b0011, 4'b0011, 4'b0011, 32'hC0000000, 1, 4'b0000, 0, 32'hC0000003, 1, 0, 0, 0);
        add(0, 4'b0011, 4'b0011, 4'b0011, 32'hC0000000, 0, 4'b0001, 0, 32'hC0000003, 1, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 1, 32'hC0000000, 0, 0, 0, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 32'hC0000000, 0, 0, 1, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 32'hC0000000, 0, 0, 2, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        1, 4'b0000, 0, 32'hC0000000, 0, 0, 3, 0);
        add(0, 4'b0000, 4'b0000, 4'b0000, 32'h0,        0, 4'b0000, 0, 32'hC0000000, 0, 0, 4, 0);

        drive(1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 0);
        repeat (2) @(posedge clk);
        #1;

        for (int k = 0; k < tbl.size(); k++) begin
            drive(tbl[k].rst, tbl[k].v, tbl[k].h, tbl[k].t, tbl[k].base, tbl[k].cr);
            obs($sformatf("row%0d", k), tbl[k].rdy, tbl[k].ov, tbl[k].of, tbl[k].lock,
                tbl[k].own, tbl[k].cnt, tbl[k].err);
            step();
        end

        // Credit exhaustion: input 1 sends six flits with no returns until the stall.
        drive(0, 4'b0010, 4'b0010, 4'b0000, 32'hD0000000, 0);
        obs("crd0", 4'b0000, 0, 32'hC0000000, 0, 0, 4, 0); step();
        obs("crd1", 4'b0010, 0, 32'hC0000000, 1, 1, 4, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0000, 32'hD0010000, 0);
        obs("crd2", 4'b0010, 1, 32'hD0000001, 1, 1, 3, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0000, 32'hD0020000, 0);
        obs("crd3", 4'b0010, 1, 32'hD0010001, 1, 1, 2, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0000, 32'hD0030000, 0);
        obs("crd4", 4'b0010, 1, 32'hD0020001, 1, 1, 1, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0000, 32'hD0040000, 0);
        obs("crd5", 4'b0000, 1, 32'hD0030001, 1, 1, 0, 0); step();
        obs("crd6", 4'b0000, 0, 32'hD0030001, 1, 1, 0, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0000, 32'hD0040000, 1);
        obs("crd7", 4'b0000, 0, 32'hD0030001, 1, 1, 0, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0000, 32'hD0040000, 0);
        obs("crd8", 4'b0010, 0, 32'hD0030001, 1, 1, 1, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0010, 32'hD0050000, 1);
        obs("crd9", 4'b0000, 1, 32'hD0040001, 1, 1, 0, 0); step();
        drive(0, 4'b0010, 4'b0000, 4'b0010, 32'hD0050000, 0);
        obs("crd10", 4'b0010, 0, 32'hD0040001, 1, 1, 1, 0); step();
        drive(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1);
        obs("crd11", 4'b0000, 1, 32'hD0050001, 0, 1, 0, 0); step();
        obs("crd12", 4'b0000, 0, 32'hD0050001, 0, 1, 1, 0); step();

        // Simultaneous transfer and return, then overflow at full credit.
        drive(0, 4'b0100, 4'b0100, 4'b0000, 32'hE0000000, 0);
        obs("ovf0", 4'b0000, 0, 32'hD0050001, 0, 1, 2, 0); step();
        drive(0, 4'b0100, 4'b0100, 4'b0000, 32'hE0000000, 1);
        obs("ovf1", 4'b0100, 0, 32'hD0050001, 1, 2, 2, 0); step();
        drive(0, 4'b0100, 4'b0000, 4'b0100, 32'hE1000000, 1);
        obs("ovf2", 4'b0100, 1, 32'hE0000002, 1, 2, 2, 0); step();
        drive(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 1);
        obs("ovf3", 4'b0000, 1, 32'hE1000002, 0, 2, 2, 0); step();
        obs("ovf4", 4'b0000, 0, 32'hE1000002, 0, 2, 3, 0); step();
        obs("ovf5", 4'b0000, 0, 32'hE1000002, 0, 2, 4, 0); step();
        obs("ovf6", 4'b0000, 0, 32'hE1000002, 0, 2, 4, 1); step();
        drive(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 0);
        obs("ovf7", 4'b0000, 0, 32'hE1000002, 0, 2, 4, 1); step();
        obs("ovf8", 4'b0000, 0, 32'hE1000002, 0, 2, 4, 1); step();

        // Reset in the middle of a packet, then re-arbitration from pointer 0.
        drive(1, 4'b0000, 4'b0000, 4'b0000, 32'h0, 0);
        obs("rst0", 4'b0000, 0, 32'hE1000002, 0, 2, 4, 1); step();
        drive(0, 4'b1000, 4'b1000, 4'b0000, 32'hF0000000, 0);
        obs("rst1", 4'b0000, 0, 32'h0, 0, 0, 4, 0); step();
        obs("rst2", 4'b1000, 0, 32'h0, 1, 3, 4, 0); step();
        drive(1, 4'b1000, 4'b0000, 4'b0000, 32'hF1000000, 0);
        obs("rst3", 4'b1000, 1, 32'hF0000003, 1, 3, 3, 0); step();
        drive(0, 4'b1010, 4'b1010, 4'b1010, 32'h00000010, 0);
        obs("rst4", 4'b0000, 0, 32'h0, 0, 0, 4, 0); step();
        obs("rst5", 4'b0010, 0, 32'h0, 1, 1, 4, 0); step();
        drive(0, 4'b0000, 4'b0000, 4'b0000, 32'h0, 0);
        obs("rst6", 4'b0000, 1, 32'h00000011, 0, 1, 3, 0); step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/router_olck_ctrl.md
# router_olck_ctrl

Output-port lock and credit controller for the router_wrap slice: the transmit-side counterpart of the per-input lock flip-flops in the slice datapath. It arbitrates among input requesters for one router output port and locks that port to the winner from head flit to tail flit. It forwards flits only while downstream buffer credits remain, and re-opens the port for round-robin arbitration after the tail flit transfers.

## Interface
Parameters:
- NUM_IN, 4, number of requesting input ports (≥2)
- FLIT_W, 32, flit payload width
- CREDITS, 4, downstream buffer depth; initial and maximum credit count (≥1)

Ports:
- clk  in  1  fabric clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  NUM_IN  per-input flit valid
- in_head  in  NUM_IN  per-input head-flit marker
- in_tail  in  NUM_IN  per-input tail-flit marker (head&tail = single-flit packet)
- in_flit  in  NUM_IN*FLIT_W  per-input payload; input i occupies bits [i*FLIT_W +: FLIT_W]
- in_ready  out  NUM_IN  per-input accept (combinational)
- out_valid  out  1  registered flit valid to downstream
- out_flit  out  FLIT_W  registered payload
- out_lock  out  1  port locked to an owner
- out_owner  out  $clog2(NUM_IN)  current/last owner index
- credit_ret  in  1  one credit returned by downstream this cycle
- credit_cnt  out  $clog2(CREDITS+1)  available credits
- credit_err  out  1  sticky credit-overflow flag

## Operation
- States: IDLE, LOCKED.
- IDLE:
  - in_ready all 0.
  - Candidates are the inputs with in_valid&in_head.
  - Round-robin selection starts at rr_ptr.
  - If any candidate exists: latch out_owner, go to LOCKED.
  - Non-head valid flits stall.
- LOCKED:
  - in_ready[out_owner] = (credit_cnt != 0); all other in_ready are 0.
  - Transfer = in_valid[owner] & in_ready[owner].
  - On transfer: out_flit <= in_flit[owner], out_valid <= 1, credit decrements.
  - Otherwise out_valid <= 0 and out_flit holds.
  - in_head on flits after the first is ignored.
  - A transfer with in_tail=1 returns the state to IDLE and sets rr_ptr <= owner+1 (mod NUM_IN).
- Credits:
  - Next count = cnt − transfer + credit_ret.
  - Transfer and credit_ret in the same cycle leave the count unchanged.
  - credit_ret while cnt==CREDITS with no transfer: count holds at CREDITS; credit_err <= 1 until reset.
  - The count never underflows, because in_ready is gated by cnt != 0.
- out_lock = (state==LOCKED).
- Reset values:
  - state IDLE, rr_ptr 0, out_owner 0
  - out_valid 0, out_flit 0, out_lock 0
  - credit_cnt CREDITS, credit_err 0
- Reset mid-packet drops the lock and restores full credits. Downstream is reset in the same cycle by the global reset.

## Timing
- Head presented in IDLE at cycle 0 → out_lock=1 and in_ready[owner]=1 at cycle 1 → flit on out_valid/out_flit at cycle 2.
- Lock latency is 1 cycle; flit latency is 1 cycle after acceptance.
- Throughput is 1 flit/cycle while credits > 0.
- With CREDITS=N and no returns, N back-to-back flits are accepted; in_ready drops in the cycle credit_cnt reaches 0.
- The first credit_ret raises in_ready again on the next cycle.
- Tail accepted at cycle t → out_lock=0 at t+1. A new owner is latched at the t+1 edge, so out_lock=1 again at t+2.
- Inputs may change only after acceptance; the block does not capture unaccepted flits.

## Structure
- Package router_olck_pkg:
  - olck_state_e (IDLE, LOCKED)
  - CREDIT_W / OWNER_W width constants derived from the parameters
- Sub-module router_rr_arbiter:
  - Combinational round-robin priority select.
  - Inputs: request vector and rr_ptr. Outputs: one-hot grant and encoded index.
- Top level holds the FSM, owner/rr_ptr registers, credit counter, output register and error flag.

## Test plan
- Reset then idle → credit_cnt=4, out_lock=0, all in_ready=0, out_valid=0, credit_err=0.
- Input 2 sends a 3-flit packet (A1,A2,A3 with tail), credit_ret=0 → out_lock at cycle 1; out_flit A1,A2,A3 at cycles 2–4; credit_cnt ends at 1; out_lock=0 after tail.
- Inputs 0 and 1 both present single-flit heads; rr_ptr=0 → input 0 served first, then input 1; rr_ptr ends at 2.
- CREDITS=4, input 1 sends 6 flits, credit_ret pulsed at cycle 7 → in_ready low after the 4th accept; 5th flit accepted the cycle after the return.
- Transfer and credit_ret in the same cycle at cnt=2 → cnt stays 2. Three credit_ret pulses at cnt=3 → cnt=4 and credit_err=1, sticky until reset.
- Assert reset during the 2nd flit of a packet → next cycle out_lock=0, out_valid=0, credit_cnt=4; a fresh head re-arbitrates from rr_ptr=0.
